// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out shift-register transmitter with valid/ready load and framing strobes
module piso_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             l,
    input  logic             load,
    output logic             ready,
    output logic             dout,
    output logic             dvalid,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             dir_q;
    logic             accept;

    // Loading on the last bit lets frames stream back-to-back with no gap.
    assign ready  = (state == IDLE) || last;
    assign accept = load && ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            dir_q  <= 1'b0;
            dout   <= 1'b0;
            dvalid <= 1'b0;
            last   <= 1'b0;
        end else if (accept) begin
            dir_q <= l;
            // First bit goes straight to dout; the rest waits at the output end of sreg.
            if (l) begin
                dout <= din[WIDTH-1];
                sreg <= {din[WIDTH-2:0], 1'b0};
            end else begin
                dout <= din[0];
                sreg <= {1'b0, din[WIDTH-1:1]};
            end
            cnt    <= CNT_INIT;
            dvalid <= 1'b1;
            last   <= 1'b0;
            state  <= SHIFT;
        end else if (state == SHIFT) begin
            if (cnt != '0) begin
                if (dir_q) begin
                    dout <= sreg[WIDTH-1];
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                end else begin
                    dout <= sreg[0];
                    sreg <= {1'b0, sreg[WIDTH-1:1]};
                end
                cnt  <= cnt - CNT_ONE;
                last <= (cnt == CNT_ONE);
            end else begin
                state  <= IDLE;
                dout   <= 1'b0;
                dvalid <= 1'b0;
                last   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - directed self-checking bench for piso_tx at WIDTH=8 and WIDTH=2
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic [7:0] din = 8'h00;
    logic       l = 1'b0;
    logic       load = 1'b0;
    logic       ready, dout, dvalid, last;

    logic [1:0] din2 = 2'b00;
    logic       l2 = 1'b0;
    logic       load2 = 1'b0;
    logic       ready2, dout2, dvalid2, last2;

    int n_cmp = 0;
    int n_bad = 0;

    piso_tx #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .din(din), .l(l), .load(load),
        .ready(ready), .dout(dout), .dvalid(dvalid), .last(last)
    );

    piso_tx #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .din(din2), .l(l2), .load(load2),
        .ready(ready2), .dout(dout2), .dvalid(dvalid2), .last(last2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Frame bits listed first-sent first in exp_bits[7] down to exp_bits[0].
    task automatic send_check(input string name, input logic [7:0] word, input logic dirl,
                              input logic [7:0] exp_bits);
        din  = word;
        l    = dirl;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s dout[%0d]", name, i), dout, exp_bits[7-i]);
            check($sformatf("%s dvalid[%0d]", name, i), dvalid, 1'b1);
            check($sformatf("%s last[%0d]", name, i), last, i == 7);
            check($sformatf("%s ready[%0d]", name, i), ready, i == 7);
            @(negedge clk);
        end
        check({name, " idle dvalid"}, dvalid, 1'b0);
        check({name, " idle dout"}, dout, 1'b0);
        check({name, " idle ready"}, ready, 1'b1);
    endtask

    initial begin
        logic [15:0] b2b_bits;
        logic [7:0]  ign_bits;
        logic [7:0]  rst_bits;
        b2b_bits = 16'b1011_0100_1111_0000;
        ign_bits = 8'b1011_0100;
        rst_bits = 8'b1000_0001;

        @(negedge clk);
        @(negedge clk);
        check("reset dout", dout, 1'b0);
        check("reset dvalid", dvalid, 1'b0);
        check("reset last", last, 1'b0);
        check("reset ready", ready, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("post-reset idle dvalid", dvalid, 1'b0);

        send_check("msb_b4", 8'hB4, 1'b1, 8'b1011_0100);
        send_check("lsb_b4", 8'hB4, 1'b0, 8'b0010_1101);

        // Back-to-back: load held high, second word presented on the last cycle.
        din  = 8'hB4;
        l    = 1'b1;
        load = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("b2b dout[%0d]", i), dout, b2b_bits[15-i]);
            check($sformatf("b2b dvalid[%0d]", i), dvalid, 1'b1);
            check($sformatf("b2b last[%0d]", i), last, (i == 7) || (i == 15));
            if (i == 7) begin
                din = 8'h0F;
                l   = 1'b0;
            end
            if (i == 15) load = 1'b0;
            @(negedge clk);
        end
        check("b2b end dvalid", dvalid, 1'b0);
        check("b2b end ready", ready, 1'b1);

        // Ignored load mid-frame.
        din  = 8'hB4;
        l    = 1'b1;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ign dout[%0d]", i), dout, ign_bits[7-i]);
            check($sformatf("ign dvalid[%0d]", i), dvalid, 1'b1);
            check($sformatf("ign last[%0d]", i), last, i == 7);
            if (i == 2) begin
                din  = 8'hFF;
                l    = 1'b0;
                load = 1'b1;
                check("ign ready during pulse", ready, 1'b0);
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ign no second frame[%0d]", i), dvalid, 1'b0);
            @(negedge clk);
        end

        // Asynchronous reset mid-frame, during cycle 4.
        din  = 8'hB4;
        l    = 1'b1;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("pre-reset dvalid", dvalid, 1'b1);
        reset = 1'b1;
        #1;
        check("async dout", dout, 1'b0);
        check("async dvalid", dvalid, 1'b0);
        check("async last", last, 1'b0);
        check("async ready", ready, 1'b1);
        #1;
        reset = 1'b0;
        din   = 8'h81;
        l     = 1'b1;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rst81 dout[%0d]", i), dout, rst_bits[7-i]);
            check($sformatf("rst81 dvalid[%0d]", i), dvalid, 1'b1);
            check($sformatf("rst81 last[%0d]", i), last, i == 7);
            @(negedge clk);
        end
        check("rst81 idle dvalid", dvalid, 1'b0);

        // WIDTH=2 instance.
        for (int d = 0; d < 2; d++) begin
            din2  = 2'b10;
            l2    = (d == 0);
            load2 = 1'b1;
            @(negedge clk);
            load2 = 1'b0;
            check($sformatf("w2 d%0d dout[0]", d), dout2, d == 0);
            check($sformatf("w2 d%0d dvalid[0]", d), dvalid2, 1'b1);
            check($sformatf("w2 d%0d last[0]", d), last2, 1'b0);
            @(negedge clk);
            check($sformatf("w2 d%0d dout[1]", d), dout2, d != 0);
            check($sformatf("w2 d%0d dvalid[1]", d), dvalid2, 1'b1);
            check($sformatf("w2 d%0d last[1]", d), last2, 1'b1);
            @(negedge clk);
            check($sformatf("w2 d%0d idle dvalid", d), dvalid2, 1'b0);
            check($sformatf("w2 d%0d idle ready", d), ready2, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
